// File: rtl/ultrasonic_scan_scheduler_pkg.sv
// Shared types and constants for the ultrasonic scan scheduler: scan FSM states,
// distance and sensor-index widths, and the "no reading" distance code.
package ultrasonic_pkg;

    localparam int DIST_W = 9;
    localparam int IDX_W  = 4;
    localparam logic [DIST_W-1:0] DIST_NONE = 9'h1FF;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } scan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultrasonic_scan_scheduler_if.sv
// Measurement/readback bus between the scan scheduler (master) and the
// navigation logic (slave).
interface ultrasonic_scan_scheduler_if;
    import ultrasonic_pkg::*;

    logic [IDX_W-1:0]  rd_addr;
    logic [DIST_W-1:0] rd_dist;
    logic              meas_valid;
    logic [IDX_W-1:0]  meas_sensor;
    logic [DIST_W-1:0] meas_dist;
    logic              meas_timeout;

    modport master (
        input  rd_addr,
        output rd_dist, meas_valid, meas_sensor, meas_dist, meas_timeout
    );

    modport slave (
        output rd_addr,
        input  rd_dist, meas_valid, meas_sensor, meas_dist, meas_timeout
    );

endinterface

// File: rtl/ultrasonic_scan_scheduler_echo_sync.sv
// Brings the asynchronous echo into the clock domain (two flops) and adds one
// delay flop so rising and falling edges can be detected.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo_rx,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic dly_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
        end else begin
            sync_p0 <= echo_rx;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~dly_p2;
    assign fall  = ~sync_p1 & dly_p2;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler for one trigger/echo pair shared by up to 16 muxed
// ultrasonic sensors, with a per-sensor distance register file.
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int SETTLE_CYCLES  = 50,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GAP_CYCLES     = 3_000_000,
    parameter int TICK_DIV       = 2900
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         echo_rx,
    output logic                         trig_tx,
    output logic [IDX_W-1:0]             mux_sensor_select,
    output logic                         busy,
    ultrasonic_scan_scheduler_if.master  nav
);

    localparam int CNT_MAX = max_int(max_int(TIMEOUT_CYCLES, GAP_CYCLES),
                                     max_int(TICK_DIV, max_int(SETTLE_CYCLES, TRIG_CYCLES)));
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RF_DEPTH = 1 << IDX_W;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ONE     = cnt_t'(1);
    localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);
    localparam cnt_t TRIG_LAST   = cnt_t'(TRIG_CYCLES - 1);
    localparam cnt_t GAP_LAST    = cnt_t'(GAP_CYCLES - 1);
    localparam cnt_t TMO_LAST    = cnt_t'(TIMEOUT_CYCLES - 1);
    localparam cnt_t TICK_LAST   = cnt_t'(TICK_DIV - 1);

    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SENSORS - 1);
    localparam logic [IDX_W:0]    NUM_SENS  = (IDX_W + 1)'(NUM_SENSORS);
    localparam logic [DIST_W-1:0] DIST_ONE  = DIST_W'(1);

    scan_state_e       state, state_next;
    cnt_t              step_cnt, step_cnt_next;
    cnt_t              tmo_cnt, tmo_cnt_next;
    cnt_t              tick_cnt, tick_cnt_next;
    logic [DIST_W-1:0] dist_cnt, dist_cnt_next;
    logic [IDX_W-1:0]  index, index_next;
    logic              rec_en;
    logic [DIST_W-1:0] rec_dist;
    logic              rec_timeout;
    logic [DIST_W-1:0] dist_rf [RF_DEPTH];

    logic echo_lvl_unused;
    logic echo_rise;
    logic echo_fall;

    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] d);
        return (d == DIST_NONE) ? d : d + DIST_ONE;
    endfunction

    echo_sync u_echo_sync (
        .clk     (clk),
        .reset   (reset),
        .echo_rx (echo_rx),
        .level   (echo_lvl_unused),
        .rise    (echo_rise),
        .fall    (echo_fall)
    );

    always_comb begin
        state_next    = state;
        step_cnt_next = step_cnt;
        tmo_cnt_next  = tmo_cnt;
        tick_cnt_next = tick_cnt;
        dist_cnt_next = dist_cnt;
        index_next    = index;
        rec_en        = 1'b0;
        rec_dist      = DIST_NONE;
        rec_timeout   = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next    = SETTLE;
                    step_cnt_next = '0;
                end
            end
            SETTLE: begin
                if (step_cnt == SETTLE_LAST) begin
                    state_next    = TRIG;
                    step_cnt_next = '0;
                end else begin
                    step_cnt_next = step_cnt + CNT_ONE;
                end
            end
            TRIG: begin
                if (step_cnt == TRIG_LAST) begin
                    state_next   = WAIT_RISE;
                    tmo_cnt_next = '0;
                end else begin
                    step_cnt_next = step_cnt + CNT_ONE;
                end
            end
            WAIT_RISE: begin
                tmo_cnt_next = tmo_cnt + CNT_ONE;
                if (tmo_cnt >= TMO_LAST) begin
                    rec_en        = 1'b1;
                    rec_timeout   = 1'b1;
                    state_next    = GAP;
                    step_cnt_next = '0;
                end else if (echo_rise) begin
                    state_next    = MEASURE;
                    tick_cnt_next = '0;
                    dist_cnt_next = '0;
                end
            end
            MEASURE: begin
                tmo_cnt_next = tmo_cnt + CNT_ONE;
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt_next = '0;
                    dist_cnt_next = sat_inc(dist_cnt);
                end else begin
                    tick_cnt_next = tick_cnt + CNT_ONE;
                end
                // The cycle carrying the fall still counts toward the distance,
                // and a fall beats a coincident timeout.
                if (echo_fall) begin
                    rec_en        = 1'b1;
                    rec_dist      = dist_cnt_next;
                    state_next    = GAP;
                    step_cnt_next = '0;
                end else if (tmo_cnt >= TMO_LAST) begin
                    rec_en        = 1'b1;
                    rec_timeout   = 1'b1;
                    state_next    = GAP;
                    step_cnt_next = '0;
                end
            end
            GAP: begin
                if (step_cnt == GAP_LAST) begin
                    index_next    = (index == IDX_LAST) ? '0 : index + IDX_ONE;
                    state_next    = enable ? SETTLE : IDLE;
                    step_cnt_next = '0;
                end else begin
                    step_cnt_next = step_cnt + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            step_cnt         <= '0;
            tmo_cnt          <= '0;
            tick_cnt         <= '0;
            dist_cnt         <= '0;
            index            <= '0;
            trig_tx          <= 1'b0;
            nav.meas_valid   <= 1'b0;
            nav.meas_sensor  <= '0;
            nav.meas_dist    <= DIST_NONE;
            nav.meas_timeout <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                dist_rf[i] <= DIST_NONE;
            end
        end else begin
            state          <= state_next;
            step_cnt       <= step_cnt_next;
            tmo_cnt        <= tmo_cnt_next;
            tick_cnt       <= tick_cnt_next;
            dist_cnt       <= dist_cnt_next;
            index          <= index_next;
            trig_tx        <= (state_next == TRIG);
            nav.meas_valid <= rec_en;
            if (rec_en) begin
                dist_rf[index]   <= rec_dist;
                nav.meas_sensor  <= index;
                nav.meas_dist    <= rec_dist;
                nav.meas_timeout <= rec_timeout;
            end
        end
    end

    assign mux_sensor_select = index;
    assign busy              = (state != IDLE);
    assign nav.rd_dist       = ({1'b0, nav.rd_addr} < NUM_SENS) ? dist_rf[nav.rd_addr] : DIST_NONE;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed-plus-random bench for ultrasonic_scan_scheduler; expected readings come
// from echo width / tick divisor and a round-robin sensor/register-file model.
module tb_ultrasonic_scan_scheduler;
    import ultrasonic_pkg::*;

    localparam int NS     = 4;
    localparam int SETTLE = 2;
    localparam int TRIG   = 4;
    localparam int TMO    = 200;
    localparam int GAP    = 10;
    localparam int TICK   = 5;
    localparam int TMO2   = 1000;
    localparam int TICK2  = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic echo_rx = 1'b0;
    logic trig_tx;
    logic busy;
    logic [IDX_W-1:0] mux_sensor_select;

    logic enable2 = 1'b0;
    logic echo2 = 1'b0;
    logic trig2;
    logic busy2;
    logic [IDX_W-1:0] mux2;

    ultrasonic_scan_scheduler_if nav_if ();
    ultrasonic_scan_scheduler_if nav2_if ();

    int vectors = 0;
    int miscompares = 0;
    int exp_idx = 0;
    int ref_rf [16];

    always #5 clk = ~clk;

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS(NS), .SETTLE_CYCLES(SETTLE), .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .TICK_DIV(TICK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .echo_rx(echo_rx),
        .trig_tx(trig_tx), .mux_sensor_select(mux_sensor_select), .busy(busy),
        .nav(nav_if)
    );

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS(NS), .SETTLE_CYCLES(SETTLE), .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO2), .GAP_CYCLES(GAP), .TICK_DIV(TICK2)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable2), .echo_rx(echo2),
        .trig_tx(trig2), .mux_sensor_select(mux2), .busy(busy2),
        .nav(nav2_if)
    );

    function automatic int model_dist(input int width, input int tick);
        int d;
        d = width / tick;
        return (d > 511) ? 511 : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: echo pulse, 1: no echo, 2: echo already high before WAIT_RISE
    task automatic scan_step(input int mode, input int delay, input int width, input int drop_at);
        int n;
        bit seen;
        int exp_d;
        bit exp_to;
        int prev;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (trig_tx) seen = 1'b1;
        end
        check("trig_start", 32'(seen), 1);
        check("mux_select", 32'(mux_sensor_select), exp_idx);
        check("busy_in_step", 32'(busy), 1);
        if (mode == 2) echo_rx = 1'b1;
        n = 0;
        while (trig_tx && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("trig_width", n, TRIG);
        if (mode == 0) begin
            repeat (delay) @(negedge clk);
            echo_rx = 1'b1;
            for (int k = 0; k < width; k++) begin
                if (k == drop_at) enable = 1'b0;
                @(negedge clk);
            end
            echo_rx = 1'b0;
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 1000) begin
            if (nav_if.meas_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("meas_valid_seen", 32'(seen), 1);
        if (mode == 1) check("timeout_latency", 32'(n >= TMO - 5 && n <= TMO + 5), 1);
        if (mode == 0) begin
            exp_d  = model_dist(width, TICK);
            exp_to = 1'b0;
        end else begin
            exp_d  = 511;
            exp_to = 1'b1;
        end
        check("meas_sensor", 32'(nav_if.meas_sensor), exp_idx);
        check("meas_dist", 32'(nav_if.meas_dist), exp_d);
        check("meas_timeout", 32'(nav_if.meas_timeout), 32'(exp_to));
        ref_rf[exp_idx] = exp_d;
        nav_if.rd_addr = 4'(exp_idx);
        #1;
        check("rd_dist", 32'(nav_if.rd_dist), ref_rf[exp_idx]);
        prev = (exp_idx + NS - 1) % NS;
        nav_if.rd_addr = 4'(prev);
        #1;
        check("rd_dist_prev", 32'(nav_if.rd_dist), ref_rf[prev]);
        @(negedge clk);
        check("valid_pulse", 32'(nav_if.meas_valid), 0);
        if (mode == 2) echo_rx = 1'b0;
        exp_idx = (exp_idx + 1) % NS;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen;
        int w;
        nav_if.rd_addr  = '0;
        nav2_if.rd_addr = '0;
        for (int i = 0; i < 16; i++) ref_rf[i] = 511;

        // reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_trig", 32'(trig_tx), 0);
        check("rst_mux", 32'(mux_sensor_select), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(nav_if.meas_valid), 0);
        check("rst_sensor", 32'(nav_if.meas_sensor), 0);
        check("rst_dist", 32'(nav_if.meas_dist), 511);
        check("rst_timeout", 32'(nav_if.meas_timeout), 0);
        for (int a = 0; a < 16; a++) begin
            nav_if.rd_addr = 4'(a);
            #1;
            check("rst_rd_dist", 32'(nav_if.rd_dist), 511);
            @(negedge clk);
        end

        // directed steps: sensors 0,1,2,3,0
        enable = 1'b1;
        scan_step(0, 5, 50, -1);
        scan_step(1, 0, 0, -1);
        scan_step(2, 0, 0, -1);
        scan_step(0, $urandom_range(1, 20), $urandom_range(1, 150), -1);
        scan_step(0, $urandom_range(1, 20), $urandom_range(1, 150), -1);

        // random steps: sensors 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 3) == 0) scan_step(1, 0, 0, -1);
            else scan_step(0, $urandom_range(1, 20), $urandom_range(1, 150), -1);
        end

        // sensor 2: enable dropped mid-MEASURE
        scan_step(0, 4, 40, 10);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (!busy) seen = 1'b1;
        end
        check("drop_idle", 32'(seen), 1);
        check("drop_mux_next", 32'(mux_sensor_select), exp_idx);
        nav_if.rd_addr = 4'd9;
        #1;
        check("rd_out_of_range", 32'(nav_if.rd_dist), 511);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (trig_tx || busy) seen = 1'b1;
        end
        check("drop_stays_idle", 32'(seen), 0);

        // re-enable resumes at sensor 3; reset lands mid-MEASURE
        enable = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (trig_tx) seen = 1'b1;
        end
        check("resume_trig", 32'(seen), 1);
        check("resume_mux", 32'(mux_sensor_select), 3);
        n = 0;
        while (trig_tx && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        echo_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_trig", 32'(trig_tx), 0);
        check("mid_rst_mux", 32'(mux_sensor_select), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(nav_if.meas_valid), 0);
        check("mid_rst_sensor", 32'(nav_if.meas_sensor), 0);
        check("mid_rst_dist", 32'(nav_if.meas_dist), 511);
        check("mid_rst_timeout", 32'(nav_if.meas_timeout), 0);
        echo_rx = 1'b0;
        enable  = 1'b0;
        for (int a = 0; a < 4; a++) begin
            nav_if.rd_addr = 4'(a);
            #1;
            check("mid_rst_rd_dist", 32'(nav_if.rd_dist), 511);
            @(negedge clk);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (nav_if.meas_valid || busy) seen = 1'b1;
        end
        check("post_rst_quiet", 32'(seen), 0);

        // saturation instance: TICK_DIV=1, TIMEOUT=1000
        enable2 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            w = (s == 0) ? 600 : 300;
            seen = 1'b0;
            n = 0;
            while (!seen && n < 100) begin
                @(negedge clk);
                n++;
                if (trig2) seen = 1'b1;
            end
            check("sat_trig_start", 32'(seen), 1);
            n = 0;
            while (trig2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
            echo2 = 1'b1;
            repeat (w) @(negedge clk);
            echo2 = 1'b0;
            seen = 1'b0;
            n = 0;
            while (!seen && n < 100) begin
                if (nav2_if.meas_valid) seen = 1'b1;
                else begin
                    @(negedge clk);
                    n++;
                end
            end
            check("sat_valid_seen", 32'(seen), 1);
            check("sat_sensor", 32'(nav2_if.meas_sensor), s);
            check("sat_dist", 32'(nav2_if.meas_dist), model_dist(w, TICK2));
            check("sat_timeout", 32'(nav2_if.meas_timeout), 0);
            @(negedge clk);
        end
        enable2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
